reg_wr_arbiter: RTL and testbench

- Shares the register file's single write port (Rv, busV, RegWr) between two write-back requesters: A (ALU result) and B (memory load).
- Each requester uses a valid/ready handshake.
- Accepted writes pass through one registered output stage into the register file.
- The block also flags read hazards against writes that are pending or waiting.

---
 rtl/reg_wr_arbiter.sv | 104 ++++++++++
 tb/tb_reg_wr_arbiter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/reg_wr_arbiter.sv
// Round-robin arbiter sharing the register-file write port between an ALU (A)
// and a load unit (B), with one registered output stage and read-hazard detection.
module reg_wr_arbiter #(
   parameter int n  = 32,
   parameter int AW = 5
) (
   input  logic          Clock,
   input  logic          Reset,
   input  logic          a_valid,
   input  logic [AW-1:0] a_addr,
   input  logic [n-1:0]  a_data,
   output logic          a_ready,
   input  logic          b_valid,
   input  logic [AW-1:0] b_addr,
   input  logic [n-1:0]  b_data,
   output logic          b_ready,
   output logic          RegWr,
   output logic [AW-1:0] Rv,
   output logic [n-1:0]  busV,
   input  logic [AW-1:0] qa,
   input  logic [AW-1:0] qb,
   output logic          hazard,
   output logic [15:0]   wr_cnt
);

   logic          regwr_q, regwr_d;
   logic [AW-1:0] rv_q, rv_d;
   logic [n-1:0]  busv_q, busv_d;
   logic          prio_q, prio_d;   // 0: A holds priority, 1: B holds priority
   logic [15:0]   cnt_q, cnt_d;
   logic          grant_a, grant_b;

   function automatic logic addr_hit(input logic [AW-1:0] x,
                                     input logic          wr_en,
                                     input logic [AW-1:0] wr_addr,
                                     input logic          av,
                                     input logic [AW-1:0] aa,
                                     input logic          bv,
                                     input logic [AW-1:0] ba);
      return (x != '0) && ((wr_en && (x == wr_addr)) ||
                           (av && (x == aa)) ||
                           (bv && (x == ba)));
   endfunction

   always_comb begin
      grant_a = !Reset && a_valid && (!b_valid || !prio_q);
      grant_b = !Reset && b_valid && (!a_valid || prio_q);
   end

   always_comb begin
      regwr_d = 1'b0;
      rv_d    = rv_q;
      busv_d  = busv_q;
      prio_d  = prio_q;
      cnt_d   = cnt_q;
      if (grant_a) begin
         prio_d = 1'b1;
         if (a_addr != '0) begin
            regwr_d = 1'b1;
            rv_d    = a_addr;
            busv_d  = a_data;
         end
      end else if (grant_b) begin
         prio_d = 1'b0;
         if (b_addr != '0) begin
            regwr_d = 1'b1;
            rv_d    = b_addr;
            busv_d  = b_data;
         end
      end
      if (regwr_d && (cnt_q != 16'hFFFF)) begin
         cnt_d = cnt_q + 16'd1;
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         regwr_q <= 1'b0;
         rv_q    <= '0;
         busv_q  <= '0;
         prio_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         regwr_q <= regwr_d;
         rv_q    <= rv_d;
         busv_q  <= busv_d;
         prio_q  <= prio_d;
         cnt_q   <= cnt_d;
      end
   end

   // Masking with Reset keeps a write caught in the output stage from reaching
   // the register file on the negedge that follows the reset request.
   assign RegWr   = regwr_q && !Reset;
   assign Rv      = rv_q;
   assign busV    = busv_q;
   assign wr_cnt  = cnt_q;
   assign a_ready = grant_a;
   assign b_ready = grant_b;
   assign hazard  = !Reset &&
                    (addr_hit(qa, regwr_q, rv_q, a_valid, a_addr, b_valid, b_addr) ||
                     addr_hit(qb, regwr_q, rv_q, a_valid, a_addr, b_valid, b_addr));

endmodule

// File: tb/tb_reg_wr_arbiter.sv
// Directed bench for reg_wr_arbiter: reset, single write, contention, collision,
// address-0 handling, hazards, mid-operation reset and counter saturation.
module tb_reg_wr_arbiter;

   localparam int n  = 32;
   localparam int AW = 5;

   logic          Clock = 1'b0;
   logic          Reset;
   logic          a_valid, b_valid;
   logic [AW-1:0] a_addr, b_addr, qa, qb;
   logic [n-1:0]  a_data, b_data;
   logic          a_ready, b_ready, RegWr, hazard;
   logic [AW-1:0] Rv;
   logic [n-1:0]  busV;
   logic [15:0]   wr_cnt;

   logic [n-1:0]  rf [32];
   int            checks   = 0;
   int            failures = 0;

   reg_wr_arbiter #(.n(n), .AW(AW)) dut (
      .Clock(Clock), .Reset(Reset),
      .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
      .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
      .RegWr(RegWr), .Rv(Rv), .busV(busV),
      .qa(qa), .qb(qb), .hazard(hazard), .wr_cnt(wr_cnt)
   );

   always #5 Clock = ~Clock;

   // Register file sitting behind the write port; commits on the negedge.
   always @(negedge Clock) begin
      if (RegWr === 1'b1) rf[Rv] <= busV;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge Clock);
      #1;
   endtask

   task automatic past_negedge();
      @(negedge Clock);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) rf[i] = '0;
      Reset = 1'b1;
      a_valid = 1'b1; a_addr = 5'd3; a_data = 32'hDEAD;
      b_valid = 1'b0; b_addr = '0;   b_data = '0;
      qa = 5'd3; qb = '0;

      // Reset held two cycles with A requesting
      step();
      chk("rst1_a_ready", a_ready, 0);
      chk("rst1_regwr", RegWr, 0);
      chk("rst1_rv", Rv, 0);
      chk("rst1_busv", busV, 0);
      chk("rst1_cnt", wr_cnt, 0);
      chk("rst1_hazard", hazard, 0);
      step();
      chk("rst2_a_ready", a_ready, 0);
      chk("rst2_regwr", RegWr, 0);

      // Release; single write addr 5 data 1234
      Reset = 1'b0; a_addr = 5'd5; a_data = 32'h1234; qa = 5'd5;
      #1;
      chk("rel_a_ready", a_ready, 1);
      chk("rel_b_ready", b_ready, 0);
      chk("pend_hazard", hazard, 1);
      step();
      a_valid = 1'b0;
      #1;
      chk("sw_regwr", RegWr, 1);
      chk("sw_rv", Rv, 5);
      chk("sw_busv", busV, 32'h1234);
      chk("sw_cnt", wr_cnt, 1);
      chk("sw_hazard_out", hazard, 1);
      past_negedge();
      chk("sw_rf5", rf[5], 32'h1234);
      step();
      chk("sw_idle_regwr", RegWr, 0);
      chk("sw_idle_rv_hold", Rv, 5);
      chk("sw_idle_busv_hold", busV, 32'h1234);
      chk("sw_idle_cnt", wr_cnt, 1);
      chk("sw_idle_hazard", hazard, 0);

      // Contention after a fresh reset: A, B, A, B
      Reset = 1'b1;
      step();
      Reset = 1'b0;
      a_valid = 1'b1; a_addr = 5'd1; a_data = 32'd11;
      b_valid = 1'b1; b_addr = 5'd2; b_data = 32'd22;
      qa = '0;
      #1;
      chk("ct0_a_ready", a_ready, 1);
      chk("ct0_b_ready", b_ready, 0);
      step();
      chk("ct1_rv", Rv, 1);
      chk("ct1_busv", busV, 11);
      chk("ct1_b_ready", b_ready, 1);
      chk("ct1_a_ready", a_ready, 0);
      step();
      chk("ct2_regwr", RegWr, 1);
      chk("ct2_rv", Rv, 2);
      chk("ct2_busv", busV, 22);
      chk("ct2_a_ready", a_ready, 1);
      step();
      chk("ct3_regwr", RegWr, 1);
      chk("ct3_rv", Rv, 1);
      chk("ct3_b_ready", b_ready, 1);
      step();
      a_valid = 1'b0; b_valid = 1'b0;
      #1;
      chk("ct4_regwr", RegWr, 1);
      chk("ct4_rv", Rv, 2);
      chk("ct4_cnt", wr_cnt, 4);
      chk("ct_idle_readies", {a_ready, b_ready}, 0);

      // Same-address collision, A holds priority
      a_valid = 1'b1; a_addr = 5'd7; a_data = 32'd70;
      b_valid = 1'b1; b_addr = 5'd7; b_data = 32'd77;
      #1;
      chk("col_a_ready", a_ready, 1);
      step();
      a_valid = 1'b0;
      #1;
      chk("col1_rv", Rv, 7);
      chk("col1_busv", busV, 70);
      chk("col1_b_ready", b_ready, 1);
      step();
      b_valid = 1'b0;
      #1;
      chk("col2_regwr", RegWr, 1);
      chk("col2_busv", busV, 77);
      step();
      chk("col3_regwr", RegWr, 0);
      chk("col3_cnt", wr_cnt, 6);
      chk("col3_rf7", rf[7], 77);

      // Address 0 from B
      b_valid = 1'b1; b_addr = '0; b_data = 32'h5; qa = '0; qb = '0;
      #1;
      chk("z_b_ready", b_ready, 1);
      chk("z_hazard", hazard, 0);
      step();
      b_valid = 1'b0;
      #1;
      chk("z_regwr", RegWr, 0);
      chk("z_cnt", wr_cnt, 6);
      chk("z_busv_hold", busV, 77);
      chk("z_rv_hold", Rv, 7);

      // Hazard on a pending A write to 4 seen through qb
      a_valid = 1'b1; a_addr = 5'd4; a_data = 32'd44; qb = 5'd4;
      #1;
      chk("hz_pending", hazard, 1);
      step();
      a_valid = 1'b0;
      #1;
      chk("hz_inflight", hazard, 1);
      chk("hz_rv", Rv, 4);
      step();
      chk("hz_cleared", hazard, 0);
      chk("hz_cnt", wr_cnt, 7);
      chk("hz_rf4", rf[4], 44);

      // Reset arriving while A's addr-9 write is in the output stage
      a_valid = 1'b1; a_addr = 5'd9; a_data = 32'd99; qa = 5'd9; qb = '0;
      step();
      a_valid = 1'b0; Reset = 1'b1;
      #1;
      chk("mr_regwr_masked", RegWr, 0);
      chk("mr_hazard", hazard, 0);
      step();
      chk("mr_regwr", RegWr, 0);
      chk("mr_cnt", wr_cnt, 0);
      chk("mr_rv", Rv, 0);
      past_negedge();
      chk("mr_rf9", rf[9], 0);
      step();
      Reset = 1'b0;
      a_valid = 1'b1; a_addr = 5'd1; a_data = 32'd1;
      b_valid = 1'b1; b_addr = 5'd2; b_data = 32'd2;
      #1;
      chk("mr_prio_a", a_ready, 1);
      chk("mr_prio_b", b_ready, 0);

      // Counter saturation: A alone, back-to-back writes
      b_valid = 1'b0;
      for (int i = 0; i < 65535; i++) step();
      chk("sat_reach", wr_cnt, 16'hFFFF);
      step();
      step();
      chk("sat_hold", wr_cnt, 16'hFFFF);
      chk("sat_regwr", RegWr, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
